sd_block_responder: RTL and testbench

// - Target (HPS-side) end of the sector-request protocol used by the HDD path: answers sd_rd/sd_wr with
//   sd_ack and moves 512-byte blocks over sd_buff_* to/from a byte-wide backing store holding a disk image.
// - Stands in for the HPS in simulation/self-hosted builds; connects where hps_io drives sd_ack/sd_buff_*.

---
 rtl/sd_resp_pkg.sv | 27 ++
 rtl/sd_resp_mount_ctl.sv | 52 +++++
 rtl/sd_block_responder.sv | 184 ++++++++++++++++++
 tb/tb_sd_block_responder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_resp_pkg.sv
// Shared types and helpers for the sector-request responder.
// Holds the FSM state encoding, block geometry and the block validity rule.
package sd_resp_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DELAY   = 3'd1,
    XFER_RD = 3'd2,
    XFER_WR = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int BLOCK_BYTES = 512;
  localparam int BLOCK_AW    = 9;

  // A block is usable when an image is mounted, the block number is inside the
  // backing store and the whole block lies inside the mounted image. The end
  // offset is formed in 64 bits so large block numbers cannot wrap.
  function automatic logic blk_valid(input logic [31:0] lba,
                                     input logic [63:0] size,
                                     input logic [31:0] nblocks);
    logic [63:0] blk_end;
    blk_end = ({32'd0, lba} + 64'd1) << BLOCK_AW;
    return (size != 64'd0) && (lba < nblocks) && (blk_end <= size);
  endfunction

endpackage

// File: rtl/sd_resp_mount_ctl.sv
// Mount bookkeeping for the sector-request responder.
// A cfg_mount pulse is remembered and published (img_size, img_readonly,
// one img_mounted pulse) only while the responder reports idle, so the
// image never changes underneath a transfer. A newer cfg_mount while one is
// still pending replaces the pending values and still yields a single pulse.
module sd_resp_mount_ctl
  import sd_resp_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        idle,
  input  logic        cfg_mount,
  input  logic [63:0] cfg_size,
  input  logic        cfg_ro,
  output logic        img_mounted,
  output logic [63:0] img_size,
  output logic        img_readonly
);

  logic        pending;
  logic [63:0] pend_size;
  logic        pend_ro;

  // pending flag and published image state; a fresh request takes priority over publishing
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pending      <= 1'b0;
      img_mounted  <= 1'b0;
      img_size     <= 64'd0;
      img_readonly <= 1'b0;
    end else begin
      img_mounted <= 1'b0;
      if (cfg_mount) begin
        pending <= 1'b1;
      end else if (pending && idle) begin
        pending      <= 1'b0;
        img_size     <= pend_size;
        img_readonly <= pend_ro;
        img_mounted  <= 1'b1;
      end
    end
  end

  // latest requested image parameters, held until published
  always_ff @(posedge clk_sys) begin
    if (cfg_mount) begin
      pend_size <= cfg_size;
      pend_ro   <= cfg_ro;
    end
  end

endmodule

// File: rtl/sd_block_responder.sv
// Target end of the sector-request protocol: answers sd_rd/sd_wr with sd_ack
// and moves one 512-byte block between the sd_buff_* port and a byte-wide
// backing store holding a disk image.
// Each byte takes two cycles: for reads the store is addressed in the first
// and its data forwarded with a strobe in the second; for writes the buffer
// address is presented in the first and the core's data written in the second.
// Invalid blocks (and writes to a read-only image) keep full timing but never
// touch the store; reads of them return 0x00.
// Optional build macro SD_RESP_STATS_EN adds saturating block counters
// stat_rd_blocks, stat_wr_blocks and stat_bad_blocks.
module sd_block_responder
  import sd_resp_pkg::*;
#(
  parameter int MEM_AW     = 23,
  parameter int IMG_BLOCKS = 4096,
  parameter int ACK_DELAY  = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  input  logic [7:0]        sd_buff_din,
  output logic              sd_buff_wr,
  input  logic              cfg_mount,
  input  logic [63:0]       cfg_size,
  input  logic              cfg_ro,
  output logic              img_mounted,
  output logic [63:0]       img_size,
  output logic              img_readonly,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata
`ifdef SD_RESP_STATS_EN
  ,
  output logic [15:0]       stat_rd_blocks,
  output logic [15:0]       stat_wr_blocks,
  output logic [15:0]       stat_bad_blocks
`endif
);

  localparam int LBA_W = MEM_AW - BLOCK_AW;
  localparam int DLY_W = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;

  state_t           state, state_nx;
  logic [8:0]       idx, idx_nx;
  logic             phase, phase_nx;
  logic [DLY_W-1:0] dly_cnt, dly_nx;
  logic             accept;

  logic             rd_dir;
  logic             blk_ok;
  logic             wr_ok;
  logic [LBA_W-1:0] lba_base;
  logic             blk_ok_now;
  logic             idle;

  logic             rd_a, rd_b, wr_b, xfer;

  assign idle       = (state == IDLE);
  assign blk_ok_now = blk_valid(sd_lba, img_size, 32'(IMG_BLOCKS));

  sd_resp_mount_ctl u_mount (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .idle         (idle),
    .cfg_mount    (cfg_mount),
    .cfg_size     (cfg_size),
    .cfg_ro       (cfg_ro),
    .img_mounted  (img_mounted),
    .img_size     (img_size),
    .img_readonly (img_readonly)
  );

  // control state: FSM, byte index, byte phase and ack delay counter
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= 9'd0;
      phase   <= 1'b0;
      dly_cnt <= '0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      phase   <= phase_nx;
      dly_cnt <= dly_nx;
    end
  end

  // next-state logic; a held request level is only acted on from IDLE
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    phase_nx = phase;
    dly_nx   = dly_cnt;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (sd_rd || sd_wr) begin
          accept   = 1'b1;
          dly_nx   = DLY_W'(ACK_DELAY - 1);
          state_nx = DELAY;
        end
      end
      DELAY: begin
        if (dly_cnt == '0) begin
          idx_nx   = 9'd0;
          phase_nx = 1'b0;
          state_nx = rd_dir ? XFER_RD : XFER_WR;
        end else begin
          dly_nx = dly_cnt - DLY_W'(1);
        end
      end
      XFER_RD, XFER_WR: begin
        phase_nx = ~phase;
        if (phase) begin
          idx_nx = idx + 9'd1;
          if (idx == 9'd511) state_nx = DONE;
        end
      end
      DONE: begin
        if (!sd_rd && !sd_wr) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // request parameters captured at acceptance; validity is judged on the full
  // 32-bit block number before it is truncated to the store's address range
  always_ff @(posedge clk_sys) begin
    if (accept) begin
      rd_dir   <= sd_rd;
      blk_ok   <= blk_ok_now;
      wr_ok    <= blk_ok_now && !img_readonly;
      lba_base <= sd_lba[LBA_W-1:0];
    end
  end

  assign xfer = (state == XFER_RD) || (state == XFER_WR);
  assign rd_a = (state == XFER_RD) && !phase;
  assign rd_b = (state == XFER_RD) && phase;
  assign wr_b = (state == XFER_WR) && phase;

  assign sd_ack       = xfer;
  assign sd_buff_addr = xfer ? idx : 9'd0;
  assign sd_buff_wr   = rd_b;
  assign sd_buff_dout = (rd_b && blk_ok) ? mem_rdata : 8'd0;
  assign mem_re       = rd_a && blk_ok;
  assign mem_we       = wr_b && wr_ok;
  assign mem_addr     = (mem_re || mem_we) ? {lba_base, idx} : '0;
  assign mem_wdata    = mem_we ? sd_buff_din : 8'd0;

`ifdef SD_RESP_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic enter_done;
  assign enter_done = (state != DONE) && (state_nx == DONE);

  // per-block counters, bumped once as each transfer completes
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      stat_rd_blocks  <= 16'd0;
      stat_wr_blocks  <= 16'd0;
      stat_bad_blocks <= 16'd0;
    end else if (enter_done) begin
      if (state == XFER_RD) begin
        if (blk_ok) stat_rd_blocks  <= sat_inc16(stat_rd_blocks);
        else        stat_bad_blocks <= sat_inc16(stat_bad_blocks);
      end else begin
        if (wr_ok)  stat_wr_blocks  <= sat_inc16(stat_wr_blocks);
        else        stat_bad_blocks <= sat_inc16(stat_bad_blocks);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sd_block_responder.sv
// Directed bench for sd_block_responder: a byte-array backing store, a core
// buffer model returning addr-derived write data, and a queue of expected
// read bytes consumed as sd_buff_wr strobes appear.
module tb_sd_block_responder;

  localparam int MEM_AW     = 23;
  localparam int IMG_BLOCKS = 4096;
  localparam int ACK_DELAY  = 8;
  localparam int MEM_BYTES  = 16384;
  localparam logic [63:0] SIZE_2M = 64'd2097152;
  localparam logic [63:0] SIZE_4M = 64'd4194304;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic [31:0]       sd_lba;
  logic              sd_rd, sd_wr;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic [7:0]        sd_buff_din = 8'd0;
  logic              sd_buff_wr;
  logic              cfg_mount;
  logic [63:0]       cfg_size;
  logic              cfg_ro;
  logic              img_mounted;
  logic [63:0]       img_size;
  logic              img_readonly;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_re;
  logic [7:0]        mem_rdata = 8'd0;
  logic              mem_we;
  logic [7:0]        mem_wdata;
`ifdef SD_RESP_STATS_EN
  logic [15:0]       stat_rd_blocks, stat_wr_blocks, stat_bad_blocks;
`endif

  logic [7:0]  mem [0:MEM_BYTES-1];
  logic        preload;
  logic [7:0]  din_xor;
  int          oob_cnt = 0;

  int checks = 0;
  int errors = 0;
  int r_lat, r_ack, r_strb, r_re, r_we, r_mnt, r_retrig;
  logic [16:0] exp_q[$];

  sd_block_responder #(
    .MEM_AW(MEM_AW), .IMG_BLOCKS(IMG_BLOCKS), .ACK_DELAY(ACK_DELAY)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr), .cfg_mount(cfg_mount),
    .cfg_size(cfg_size), .cfg_ro(cfg_ro), .img_mounted(img_mounted), .img_size(img_size),
    .img_readonly(img_readonly), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata)
`ifdef SD_RESP_STATS_EN
    , .stat_rd_blocks(stat_rd_blocks), .stat_wr_blocks(stat_wr_blocks),
    .stat_bad_blocks(stat_bad_blocks)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] init_byte(input int a);
    logic [8:0] b;
    b = a[8:0];
    return ((a >> 9) == 3) ? (b[7:0] ^ 8'h5A) : 8'hEE;
  endfunction

  // backing store: read data one cycle after mem_re, garbage otherwise
  always @(posedge clk_sys) begin
    if (preload) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= init_byte(i);
    end else begin
      mem_rdata <= 8'hC3;
      if (mem_re || mem_we) begin
        if (mem_addr[MEM_AW-1:14] != '0) oob_cnt <= oob_cnt + 1;
        else if (mem_re) mem_rdata <= mem[mem_addr[13:0]];
        else mem[mem_addr[13:0]] <= mem_wdata;
      end
    end
  end

  // core-side buffer: write data follows the buffer address by one cycle
  always @(posedge clk_sys) sd_buff_din <= sd_buff_addr[7:0] ^ din_xor;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_blk(input bit pattern);
    for (int i = 0; i < 512; i++)
      exp_q.push_back({9'(i), pattern ? (8'(i) ^ 8'h5A) : 8'h00});
  endtask

  task automatic mount(input logic [63:0] size, input bit ro);
    int n;
    @(negedge clk_sys);
    cfg_size = size; cfg_ro = ro; cfg_mount = 1'b1;
    @(negedge clk_sys);
    cfg_mount = 1'b0;
    n = 0;
    while (!img_mounted && n < 20) begin @(negedge clk_sys); n++; end
    chk("mount_pulse", 64'(img_mounted), 64'd1);
    chk("mount_size", img_size, size);
    chk("mount_ro", 64'(img_readonly), 64'(ro));
    @(negedge clk_sys);
    chk("mount_once", 64'(img_mounted), 64'd0);
  endtask

  // one full request: latency, 1024 ack cycles, held level must not re-trigger
  task automatic xfer(input bit do_rd, input bit do_wr, input logic [31:0] lba, input int mount_at);
    logic [16:0] e;
    r_lat = 0; r_ack = 0; r_strb = 0; r_re = 0; r_we = 0; r_mnt = 0; r_retrig = 0;
    @(negedge clk_sys);
    sd_lba = lba; sd_rd = do_rd; sd_wr = do_wr;
    while (!sd_ack && r_lat < 100) begin @(negedge clk_sys); r_lat++; end
    while (sd_ack && r_ack < 3000) begin
      r_ack++;
      cfg_mount = (r_ack == mount_at);
      if (sd_buff_wr) begin
        r_strb++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rd_addr", 64'(sd_buff_addr), 64'(e[16:8]));
          chk("rd_data", 64'(sd_buff_dout), 64'(e[7:0]));
        end
      end
      if (mem_re) r_re++;
      if (mem_we) r_we++;
      if (img_mounted) r_mnt++;
      @(negedge clk_sys);
    end
    cfg_mount = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (sd_ack) r_retrig++;
      @(negedge clk_sys);
    end
    sd_rd = 1'b0; sd_wr = 1'b0;
    chk("ack_latency", 64'(r_lat), 64'(ACK_DELAY + 1));
    chk("ack_cycles", 64'(r_ack), 64'd1024);
    chk("no_retrigger", 64'(r_retrig), 64'd0);
  endtask

  initial begin
    int n, bad;
    sd_lba = 0; sd_rd = 0; sd_wr = 0; cfg_mount = 0; cfg_size = 0; cfg_ro = 0;
    din_xor = 8'h00; preload = 1'b1; reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    preload = 1'b0; reset = 1'b0;
    @(negedge clk_sys);

    // reset state
    chk("rst_ack", 64'(sd_ack), 64'd0);
    chk("rst_buff_wr", 64'(sd_buff_wr), 64'd0);
    chk("rst_buff_addr", 64'(sd_buff_addr), 64'd0);
    chk("rst_mem_re", 64'(mem_re), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_img_size", img_size, 64'd0);
    chk("rst_img_mounted", 64'(img_mounted), 64'd0);

    // read of preloaded block 3
    mount(SIZE_2M, 1'b0);
    push_blk(1'b1);
    xfer(1'b1, 1'b0, 32'd3, -1);
    chk("rd3_strobes", 64'(r_strb), 64'd512);
    chk("rd3_mem_re", 64'(r_re), 64'd512);
    chk("rd3_mem_we", 64'(r_we), 64'd0);
    chk("rd3_q_empty", 64'(exp_q.size()), 64'd0);

    // write of block 7 with data = byte index
    xfer(1'b0, 1'b1, 32'd7, -1);
    chk("wr7_mem_we", 64'(r_we), 64'd512);
    chk("wr7_strobes", 64'(r_strb), 64'd0);
    bad = 0;
    for (int i = 0; i < 512; i++) if (mem[7*512+i] !== 8'(i)) bad++;
    chk("wr7_content", 64'(bad), 64'd0);
    chk("wr7_below", 64'(mem[7*512-1]), 64'hEE);
    chk("wr7_above", 64'(mem[8*512]), 64'hEE);

    // read-only image: write is timed but blocked
    mount(SIZE_2M, 1'b1);
    din_xor = 8'hFF;
    xfer(1'b0, 1'b1, 32'd7, -1);
    din_xor = 8'h00;
    chk("ro_mem_we", 64'(r_we), 64'd0);
    bad = 0;
    for (int i = 0; i < 512; i++) if (mem[7*512+i] !== 8'(i)) bad++;
    chk("ro_unchanged", 64'(bad), 64'd0);
`ifdef SD_RESP_STATS_EN
    chk("stat_rd", 64'(stat_rd_blocks), 64'd1);
    chk("stat_wr", 64'(stat_wr_blocks), 64'd1);
    chk("stat_bad", 64'(stat_bad_blocks), 64'd1);
`endif

    // block number at the backing-store limit, image large enough
    mount(SIZE_4M, 1'b0);
    push_blk(1'b0);
    xfer(1'b1, 1'b0, 32'(IMG_BLOCKS), -1);
    chk("oor_strobes", 64'(r_strb), 64'd512);
    chk("oor_mem_re", 64'(r_re), 64'd0);

    // image of exactly 4 blocks: block 3 readable, block 4 not writable
    mount(64'd2048, 1'b0);
    push_blk(1'b1);
    xfer(1'b1, 1'b0, 32'd3, -1);
    chk("edge_rd_mem_re", 64'(r_re), 64'd512);
    xfer(1'b0, 1'b1, 32'd4, -1);
    chk("edge_wr_mem_we", 64'(r_we), 64'd0);

    // unmounted image
    mount(64'd0, 1'b0);
    push_blk(1'b0);
    xfer(1'b1, 1'b0, 32'd3, -1);
    chk("unm_strobes", 64'(r_strb), 64'd512);
    chk("unm_mem_re", 64'(r_re), 64'd0);

    // both requests high reads; a mount mid-transfer is deferred until idle
    mount(SIZE_2M, 1'b0);
    cfg_ro = 1'b1;
    push_blk(1'b1);
    xfer(1'b1, 1'b1, 32'd3, 300);
    chk("both_strobes", 64'(r_strb), 64'd512);
    chk("both_mem_we", 64'(r_we), 64'd0);
    chk("both_no_mount_in_xfer", 64'(r_mnt), 64'd0);
    n = 0;
    do begin @(negedge clk_sys); n++; end while (!img_mounted && n < 20);
    chk("deferred_mount_delay", 64'(n), 64'd2);
    chk("deferred_mount_ro", 64'(img_readonly), 64'd1);

    // reset asserted while byte 200 of a write to block 0 is in progress
    mount(SIZE_2M, 1'b0);
    @(negedge clk_sys);
    sd_lba = 32'd0; sd_wr = 1'b1;
    n = 0;
    while (!sd_ack && n < 100) begin @(negedge clk_sys); n++; end
    r_we = 0; n = 0;
    while (r_we < 200 && n < 3000) begin
      @(negedge clk_sys); n++;
      if (mem_we) r_we++;
    end
    chk("rstw_reached", 64'(r_we), 64'd200);
    @(posedge clk_sys);
    #1 reset = 1'b1;
    #1;
    chk("rstw_ack_drop", 64'(sd_ack), 64'd0);
    chk("rstw_we_drop", 64'(mem_we), 64'd0);
    @(negedge clk_sys);
    sd_wr = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("rstw_unmounted", img_size, 64'd0);
    bad = 0;
    for (int i = 0; i < 200; i++) if (mem[i] !== 8'(i)) bad++;
    chk("rstw_written", 64'(bad), 64'd0);
    bad = 0;
    for (int i = 200; i < 512; i++) if (mem[i] !== 8'hEE) bad++;
    chk("rstw_untouched", 64'(bad), 64'd0);

    // normal service after the abort
    mount(SIZE_2M, 1'b0);
    push_blk(1'b1);
    xfer(1'b1, 1'b0, 32'd3, -1);
    chk("post_rst_strobes", 64'(r_strb), 64'd512);
    chk("post_rst_mem_re", 64'(r_re), 64'd512);
    chk("post_rst_q_empty", 64'(exp_q.size()), 64'd0);

    chk("mem_addr_in_range", 64'(oob_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
